// File: rtl/fe_issue_queue.sv
// fe_issue_queue: in-order decoded-instruction buffer between the front end
// and dispatch. Generates the front-end stall (ready_o), drops all entries
// on a mispredict flush, and counts buffered speculative branches.
module fe_issue_queue #(
  parameter int ELS_P   = 4,
  parameter int WIDTH_P = 32  // set to the decoded-instruction width at instantiation
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic                         valid_i,
  input  logic [WIDTH_P-1:0]           data_i,
  input  logic                         spec_i,
  output logic                         ready_o,
  output logic                         valid_o,
  output logic [WIDTH_P-1:0]           data_o,
  input  logic                         yumi_i,
  output logic [$clog2(ELS_P+1)-1:0]   count_o,
  output logic [$clog2(ELS_P+1)-1:0]   spec_count_o
);

  localparam int PW = $clog2(ELS_P);
  localparam int CW = $clog2(ELS_P+1);

  logic [WIDTH_P-1:0] mem_q [ELS_P];
  logic [ELS_P-1:0]   spec_mem_q;

  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d, spec_count_q, spec_count_d;
  logic          enq, deq;

  // ready_o comes from registers only so the front-end stall has no loop
  // through valid_i/yumi_i; a same-cycle deq does not open a full queue.
  assign ready_o      = (count_q != CW'(ELS_P));
  assign valid_o      = (count_q != '0) & ~flush_i;
  assign data_o       = mem_q[rptr_q];
  assign count_o      = count_q;
  assign spec_count_o = spec_count_q;

  assign enq = valid_i & ready_o & ~flush_i;
  assign deq = yumi_i & valid_o;

  // Next-state for pointers and counters; flush wins over enq/deq.
  always_comb begin
    rptr_d       = rptr_q;
    wptr_d       = wptr_q;
    count_d      = count_q;
    spec_count_d = spec_count_q;
    if (flush_i) begin
      rptr_d       = '0;
      wptr_d       = '0;
      count_d      = '0;
      spec_count_d = '0;
    end else begin
      if (enq) wptr_d = wptr_q + PW'(1);
      if (deq) rptr_d = rptr_q + PW'(1);
      count_d      = count_q + CW'(enq) - CW'(deq);
      spec_count_d = spec_count_q + CW'(enq & spec_i)
                                  - CW'(deq & spec_mem_q[rptr_q]);
    end
  end

  // Control state; async reset discards every entry.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_q       <= '0;
      wptr_q       <= '0;
      count_q      <= '0;
      spec_count_q <= '0;
    end else begin
      rptr_q       <= rptr_d;
      wptr_q       <= wptr_d;
      count_q      <= count_d;
      spec_count_q <= spec_count_d;
    end
  end

  // Storage writes; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wptr_q]      <= data_i;
      spec_mem_q[wptr_q] <= spec_i;
    end
  end

  // Dispatch must not consume an empty head (flush cycles excepted).
  a_no_yumi_when_empty: assert property (@(posedge clk_i) disable iff (reset_i)
    !(yumi_i && !valid_o && !flush_i));

endmodule

// File: tb/tb_fe_issue_queue.sv
// Self-checking bench for fe_issue_queue: queue-based reference model with a
// per-cycle compare process, directed scenarios and a random phase.
module tb_fe_issue_queue;

  localparam int ELS = 4;
  localparam int W   = 8;
  localparam int CW  = $clog2(ELS+1);

  logic          clk_i = 0;
  logic          reset_i = 1;
  logic          flush_i = 0, valid_i = 0, spec_i = 0, yumi_i = 0;
  logic [W-1:0]  data_i = '0;
  logic          ready_o, valid_o;
  logic [W-1:0]  data_o;
  logic [CW-1:0] count_o, spec_count_o;

  int checks = 0;
  int errors = 0;

  fe_issue_queue #(.ELS_P(ELS), .WIDTH_P(W)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i), .valid_i(valid_i),
    .data_i(data_i), .spec_i(spec_i), .ready_o(ready_o), .valid_o(valid_o),
    .data_o(data_o), .yumi_i(yumi_i), .count_o(count_o),
    .spec_count_o(spec_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of {spec, data}.
  logic [W:0] mq[$];
  bit m_enq, m_deq;

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) mq.delete();
    else if (flush_i) mq.delete();
    else begin
      m_enq = valid_i && (mq.size() < ELS);
      m_deq = yumi_i && (mq.size() > 0);
      if (m_deq) void'(mq.pop_front());
      if (m_enq) mq.push_back({spec_i, data_i});
    end
  end

  // Compare DUT against the model every cycle, mid-period.
  always @(negedge clk_i) begin
    int sc;
    sc = 0;
    foreach (mq[k]) sc += int'(mq[k][W]);
    if (reset_i) begin
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_ready", 32'(ready_o), 1);
      chk("rst_count", 32'(count_o), 0);
      chk("rst_spec",  32'(spec_count_o), 0);
    end else begin
      chk("valid", 32'(valid_o), 32'((mq.size() > 0) && !flush_i));
      chk("ready", 32'(ready_o), 32'(mq.size() != ELS));
      chk("count", 32'(count_o), 32'(mq.size()));
      chk("spec_count", 32'(spec_count_o), 32'(sc));
      chk("invariant", 32'((spec_count_o <= count_o) && (count_o <= CW'(ELS))), 1);
      if (mq.size() > 0 && !flush_i) chk("data", 32'(data_o), 32'(mq[0][W-1:0]));
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] d, input logic s,
                       input logic y, input logic f);
    valid_i = v; data_i = d; spec_i = s; yumi_i = y; flush_i = f;
    @(posedge clk_i); #1;
    valid_i = 0; yumi_i = 0; flush_i = 0; spec_i = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && mq.size() > 0; n++) drive(0, 0, 0, 1, 0);
    chk("drain_empty", 32'(count_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk_i);
    #1 reset_i = 0;

    // 1. async reset with two entries queued
    drive(1, 8'hA1, 0, 0, 0);
    drive(1, 8'hA2, 1, 0, 0);
    chk("pre_rst_count", 32'(count_o), 2);
    #2 reset_i = 1;
    #1;
    chk("async_valid", 32'(valid_o), 0);
    chk("async_count", 32'(count_o), 0);
    chk("async_ready", 32'(ready_o), 1);
    @(posedge clk_i); #1 reset_i = 0;
    drive(0, 0, 0, 0, 0);
    chk("post_rst_valid", 32'(valid_o), 0);

    // 2. fill to full
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'(8'h11 * (i + 1)), 0, 0, 0);
      chk("fill_count", 32'(count_o), 32'(i + 1));
    end
    chk("full_ready", 32'(ready_o), 0);
    drive(1, 8'h55, 0, 0, 0);
    chk("full_noacc", 32'(count_o), 4);
    chk("full_head", 32'(data_o), 32'h11);
    drain();

    // 3. steady stream at count 2
    drive(1, 8'h60, 0, 0, 0);
    drive(1, 8'h61, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(1, 8'(8'h62 + i), 0, 1, 0);
      chk("stream_count", 32'(count_o), 2);
    end
    drain();

    // 4. wrap-around with random yumi
    begin
      int sent;
      sent = 0;
      for (int n = 0; n < 200 && (sent < 10 || mq.size() > 0); n++) begin
        logic v, y;
        v = (sent < 10);
        y = ($urandom_range(0, 1) == 1) && (mq.size() > 0);
        if (v && mq.size() < ELS) begin
          drive(1, 8'(sent + 1), 0, y, 0);
          sent++;
        end else drive(0, 0, 0, y, 0);
      end
      chk("wrap_sent", 32'(sent), 10);
      chk("wrap_final", 32'(count_o), 0);
    end

    // 5. flush with concurrent enq and yumi
    drive(1, 8'h71, 1, 0, 0);
    drive(1, 8'h72, 1, 0, 0);
    drive(1, 8'h73, 0, 0, 0);
    chk("preflush_spec", 32'(spec_count_o), 2);
    valid_i = 1; data_i = 8'hEE; spec_i = 1; yumi_i = 1; flush_i = 1;
    #1 chk("flush_valid", 32'(valid_o), 0);
    @(posedge clk_i); #1;
    valid_i = 0; yumi_i = 0; flush_i = 0; spec_i = 0;
    chk("postflush_count", 32'(count_o), 0);
    chk("postflush_spec", 32'(spec_count_o), 0);
    chk("postflush_ready", 32'(ready_o), 1);
    chk("postflush_valid", 32'(valid_o), 0);

    // 6. spec tracking
    drive(1, 8'h81, 1, 0, 0); chk("spec1", 32'(spec_count_o), 1);
    drive(1, 8'h82, 0, 0, 0); chk("spec2", 32'(spec_count_o), 1);
    drive(1, 8'h83, 1, 0, 0); chk("spec3", 32'(spec_count_o), 2);
    drive(0, 0, 0, 1, 0);     chk("spec_deq1", 32'(spec_count_o), 1);
    drive(0, 0, 0, 1, 0);     chk("spec_deq2", 32'(spec_count_o), 1);
    drain();

    // Random phase
    for (int n = 0; n < 400; n++) begin
      logic v, s, y, f;
      v = $urandom_range(0, 3) != 0;
      s = $urandom_range(0, 1) == 1;
      y = ($urandom_range(0, 2) != 0) && (mq.size() > 0);
      f = $urandom_range(0, 19) == 0;
      drive(v, 8'($urandom), s, y, f);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fe_issue_queue.md
Name: fe_issue_queue

Overview:
Back-end receiving end of the front-end decoded-instruction interface.
- Buffers decoded instructions from the front end in an in-order FIFO and presents them to dispatch.
- Generates the front end's `ready_i` (stall) and drops every buffered entry on a mispredict flush.
- Tracks how many buffered entries are speculatively predicted branches.

Parameters:
- ELS_P, 4, queue depth; power of two, ≥ 2.
- WIDTH_P, DECODED_INSTRUCTION_WIDTH, width of one decoded-instruction entry.

Ports:
- clk_i  input  1  single clock.
- reset_i  input  1  asynchronous, active-high reset.
- flush_i  input  1  mispredict flush; same signal the front end sees as `mis_predict`.
- valid_i  input  1  front-end instruction valid (front-end `valid_o`).
- data_i  input  WIDTH_P  decoded instruction (front-end `final_decoded_instruction`).
- spec_i  input  1  `branch_speculation` bit of `data_i`.
- ready_o  output  1  queue can accept; drives front-end `ready_i`.
- valid_o  output  1  head entry valid toward dispatch.
- data_o  output  WIDTH_P  head entry.
- yumi_i  input  1  dispatch consumes the head this cycle; legal only when `valid_o`=1.
- count_o  output  $clog2(ELS_P+1)  number of occupied entries.
- spec_count_o  output  $clog2(ELS_P+1)  number of occupied entries with spec=1.

Behaviour:
- **Reset:** async assert clears rptr, wptr, count, spec_count immediately. While reset is held: `valid_o`=0, `ready_o`=1, `count_o`=0, `spec_count_o`=0. Storage array is not reset. Reset mid-operation discards all entries.
- **Handshake:**
  - enq = `valid_i` & `ready_o` & ~`flush_i`.
  - deq = `yumi_i` & `valid_o`.
- **ready_o:** = (count != ELS_P). Derived from registers only, with no path from `valid_i`/`yumi_i`, so no combinational loop through the front-end stall. No pass-through when full: a deq in the same cycle does not raise `ready_o`.
- **valid_o:** = (count != 0) & ~`flush_i`. `data_o` = mem[rptr], driven combinationally from storage.
- **Latency:** minimum 1 cycle. An entry enqueued in cycle N is visible at the head in N+1 if the queue was empty. There is no bypass.
- **Enqueue (rising edge):** mem[wptr] ← data_i, spec_mem[wptr] ← spec_i, wptr ← wptr+1 modulo ELS_P.
- **Dequeue:** rptr ← rptr+1 modulo ELS_P. Pointers are $clog2(ELS_P) bits and wrap naturally.
- **count update:** count ← count + enq − deq. Simultaneous enq and deq at 0 < count < ELS_P leaves count unchanged and preserves order.
- **spec_count update:** spec_count ← spec_count + (enq & spec_i) − (deq & spec_mem[rptr]).
- **Flush (synchronous, priority over enq/deq):**
  - Next edge: rptr=wptr=0, count=0, spec_count=0.
  - An incoming enq in the flush cycle is discarded.
  - `yumi_i` in the flush cycle has no effect.
  - Cycle after flush: `valid_o`=0, `ready_o`=1.
- **Error:** `yumi_i`=1 while `valid_o`=0 is illegal. Simulation assertion fires; state is unchanged.
- **Invariant:** `spec_count_o` ≤ `count_o` ≤ ELS_P at all times.

Test Plan:
1. **Reset:** assert reset_i asynchronously between edges with 2 entries queued → same cycle: `valid_o`=0, `count_o`=0, `ready_o`=1. After release, `valid_o` stays 0 until a new enq.
2. **Fill:** enq 0x11, 0x22, 0x33, 0x44 on consecutive cycles with yumi_i=0 → `count_o` 1, 2, 3, 4; `ready_o`=0 after the 4th edge. A 5th valid_i=1 is not accepted; `data_o`=0x11.
3. **Steady stream:** count=2, enq and deq every cycle for 6 cycles → `count_o` stays 2; output order equals input order exactly.
4. **Wrap-around:** stream 10 entries (0x01..0x0A) with random yumi_i → all 10 delivered in order across pointer wrap; final `count_o`=0.
5. **Flush:** 3 entries queued (2 with spec=1), flush_i=1 together with valid_i=1 and yumi_i=1 → during flush `valid_o`=0. Next cycle `count_o`=0, `spec_count_o`=0, `ready_o`=1, `valid_o`=0; the flushed enq never appears.
6. **Spec tracking:** enq spec pattern 1, 0, 1, then deq 2 → `spec_count_o` 1, 1, 2, then 1 after the 1st deq, then 1 after the 2nd deq.
